uart_recv_flit: RTL and testbench

UART receiver that reassembles one WIDTH-bit flit from a stream of 8N1 bytes sent LSB-first, and buffers complete flits in a small first-word-fall-through FIFO.
Byte k carries flit bits [8k+7:8k]. The final byte carries the remaining WIDTH mod 8 bits; its upper bits are padding and are ignored.
Sits at the host-to-router boundary and feeds the network injection port through a valid/ready handshake.

---
 rtl/uart_recv_flit_pkg.sv | 22 ++
 rtl/uart_recv_flit_if.sv | 11 +
 rtl/uart_recv_flit_fifo.sv | 61 ++++++
 rtl/uart_recv_flit.sv | 189 ++++++++++++++++++
 tb/tb_uart_recv_flit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_recv_flit_pkg.sv
// Shared definitions for the UART flit link: receiver FSM encoding,
// baud/byte-count helpers and the flit width agreed by both link ends.
package uart_flit_pkg;

  localparam int WIDTH = 66;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_recv_flit_if.sv
// Valid/ready flit handshake between the UART receiver and the router injection port.
interface uart_recv_flit_if #(
  parameter int WIDTH = uart_flit_pkg::WIDTH
);
  logic [WIDTH-1:0] flit_dout;
  logic             flit_valid;
  logic             flit_ready;

  modport master (output flit_dout, output flit_valid, input flit_ready);
  modport slave  (input flit_dout, input flit_valid, output flit_ready);
endinterface

// File: rtl/uart_recv_flit_fifo.sv
// First-word-fall-through flit FIFO; a push into a full FIFO is honoured only
// when a pop frees a slot in the same cycle, otherwise it is dropped and flagged.
module flit_rx_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             overflow_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             ovf_q;
  logic             empty_s, full_s, do_pop_s, do_push_s;

  assign empty_s   = (count_q == '0);
  assign full_s    = (count_q == (AW+1)'(DEPTH));
  assign do_pop_s  = pop_i && !empty_s;
  assign do_push_s = push_i && (!full_s || do_pop_s);

  assign dout_o     = mem_q[rd_ptr_q];
  assign valid_o    = !empty_s;
  assign full_o     = full_s;
  assign overflow_o = ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      ovf_q <= push_i && full_s && !do_pop_s;
    end
  end

endmodule

// File: rtl/uart_recv_flit.sv
// 8N1 UART receiver that assembles LSB-first bytes into WIDTH-bit flits and
// hands them to the router through a small FWFT FIFO.
module uart_recv_flit #(
  parameter int WIDTH        = uart_flit_pkg::WIDTH,
  parameter int CLK_FREQ     = 50000000,
  parameter int UART_BPS     = 9600,
  parameter int DEPTH        = 8,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               uart_rxd,
  uart_recv_flit_if.master   flit_if,
  output logic               fifo_full,
  output logic               frame_err,
  output logic               overflow_err,
  output logic               timeout_err
);
  import uart_flit_pkg::*;

  localparam int BPS_CNT  = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int HALF     = BPS_CNT / 2;
  localparam int NBYTES   = nbytes(WIDTH);
  localparam int LAST_W   = WIDTH - 8 * (NBYTES - 1);
  localparam int TO_LIMIT = TIMEOUT_BITS * BPS_CNT;
  localparam int CW       = $clog2(BPS_CNT);
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam int IW       = $clog2(NBYTES + 1);

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       byte_sr_q, byte_sr_d;
  logic [WIDTH-1:0] flit_sr_q, flit_sr_d;
  logic [IW-1:0]    byte_idx_q, byte_idx_d;
  logic [TW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             push_q, push_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_q, timeout_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             fall_s, last_s;

  assign fall_s = prev_q && !sync2_q;
  assign last_s = (byte_idx_q == IW'(NBYTES - 1));

  // Two-flop synchronizer plus one history flop for start-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= 3'd0;
      byte_sr_q   <= 8'd0;
      flit_sr_q   <= '0;
      byte_idx_q  <= '0;
      idle_cnt_q  <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_sr_q   <= byte_sr_d;
      flit_sr_q   <= flit_sr_d;
      byte_idx_q  <= byte_idx_d;
      idle_cnt_q  <= idle_cnt_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_sr_d   = byte_sr_q;
    flit_sr_d   = flit_sr_q;
    byte_idx_d  = byte_idx_q;
    idle_cnt_d  = idle_cnt_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (fall_s) begin
          state_d    = START;
          idle_cnt_d = '0;
        end else if (byte_idx_q != '0) begin
          // A stalled host must not leave a half-built flit waiting forever.
          if (idle_cnt_q == TW'(TO_LIMIT - 1)) begin
            byte_idx_d = '0;
            timeout_d  = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == CW'(HALF)) begin
          clk_cnt_d = '0;
          if (!sync2_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == CW'(BPS_CNT - 1)) begin
          clk_cnt_d            = '0;
          byte_sr_d[bit_cnt_q] = sync2_q;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == CW'(BPS_CNT - 1)) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (sync2_q) begin
            for (int k = 0; k < NBYTES - 1; k++) begin
              flit_sr_d[8*k +: 8] = (byte_idx_q == IW'(k)) ? byte_sr_q : flit_sr_q[8*k +: 8];
            end
            // Final byte only carries WIDTH mod 8 bits; its padding is dropped here.
            flit_sr_d[WIDTH-1 : 8*(NBYTES-1)] = last_s ? byte_sr_q[LAST_W-1:0]
                                                       : flit_sr_q[WIDTH-1 : 8*(NBYTES-1)];
            if (last_s) begin
              push_d     = 1'b1;
              byte_idx_d = '0;
            end else begin
              byte_idx_d = byte_idx_q + IW'(1);
            end
          end else begin
            frame_err_d = 1'b1;
            byte_idx_d  = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  flit_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .push_i     (push_q),
    .din_i      (flit_sr_q),
    .pop_i      (flit_if.flit_ready),
    .dout_o     (flit_if.flit_dout),
    .valid_o    (flit_if.flit_valid),
    .full_o     (fifo_full),
    .overflow_o (overflow_err)
  );

  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_recv_flit.sv
// Directed bench for uart_recv_flit: a queue model of the FIFO is checked every
// cycle, and hand-computed flit sequences and error counts pin each scenario.
module tb_uart_recv_flit;
  localparam int W     = 66;
  localparam int DEPTH = 8;
  localparam int BPS   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rxd   = 1'b1;
  logic fifo_full, frame_err, overflow_err, timeout_err;

  uart_recv_flit_if #(.WIDTH(W)) fif ();

  uart_recv_flit #(
    .WIDTH        (W),
    .CLK_FREQ     (1000000),
    .UART_BPS     (100000),
    .DEPTH        (DEPTH),
    .TIMEOUT_BITS (20)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .uart_rxd     (rxd),
    .flit_if      (fif),
    .fifo_full    (fifo_full),
    .frame_err    (frame_err),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int frame_cnt = 0, ovf_cnt = 0, to_cnt = 0, exp_ovf = 0;
  bit chk_en = 1'b0;
  logic [W-1:0] mq [$];
  logic [W-1:0] got_q [$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of the DUT against the queue model.
  task automatic compare();
    if (chk_en) begin
      chk("flit_valid", W'(fif.flit_valid), W'(mq.size() != 0));
      chk("fifo_full", W'(fifo_full), W'(mq.size() == DEPTH));
      if (fif.flit_valid && fif.flit_ready) begin
        got_q.push_back(fif.flit_dout);
        if (mq.size() != 0) begin
          chk("flit_dout", fif.flit_dout, mq[0]);
          void'(mq.pop_front());
        end
      end
      if (frame_err)    frame_cnt++;
      if (overflow_err) ovf_cnt++;
      if (timeout_err)  to_cnt++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BPS) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input bit ready_at_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    rxd = stop_v;
    if (ready_at_stop) begin
      repeat (BPS - 1) step();
      fif.flit_ready = 1'b1;
      step();
    end else begin
      repeat (BPS) step();
    end
  endtask

  task automatic model_push(input logic [W-1:0] f);
    if (mq.size() == DEPTH) exp_ovf++;
    else mq.push_back(f);
  endtask

  task automatic send_flit(input logic [W-1:0] f, input logic [5:0] pad, input bit ready_at_stop);
    logic [71:0] fx;
    fx = {pad, f};
    for (int k = 0; k < 9; k++) send_byte(fx[8*k +: 8], 1'b1, ready_at_stop && (k == 8));
    model_push(f);
  endtask

  task automatic drain();
    fif.flit_ready = 1'b1;
    repeat (20) step();
  endtask

  task automatic check_seq_inc(input string nm, input int n);
    chk({nm, "_count"}, W'(got_q.size()), W'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) chk(nm, got_q[i], W'(i + 1));
  endtask

  int f0, t0, o0, to_n;

  initial begin
    fif.flit_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", W'(fif.flit_valid), W'(0));
    chk("rst_dout", fif.flit_dout, W'(0));
    chk("rst_full", W'(fifo_full), W'(0));
    chk("rst_errs", W'({frame_err, overflow_err, timeout_err}), W'(0));
    repeat (3) step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (5) step();

    // 1: basic flit
    got_q.delete(); f0 = frame_cnt; t0 = to_cnt; o0 = ovf_cnt;
    fif.flit_ready = 1'b1;
    send_flit(66'h2_A5A5_1234_DEAD_BEEF, 6'd0, 1'b0);
    drain();
    chk("s1_count", W'(got_q.size()), W'(1));
    if (got_q.size() > 0) chk("s1_flit", got_q[0], 66'h2_A5A5_1234_DEAD_BEEF);
    chk("s1_errs", W'(frame_cnt - f0 + to_cnt - t0 + ovf_cnt - o0), W'(0));

    // 2: padding in final byte ignored, then all-zero flit
    got_q.delete();
    send_flit(66'h3_FFFF_FFFF_FFFF_FFFF, 6'h3F, 1'b0);
    send_flit(66'h0, 6'd0, 1'b0);
    drain();
    chk("s2_count", W'(got_q.size()), W'(2));
    if (got_q.size() > 1) begin
      chk("s2_flit0", got_q[0], 66'h3_FFFF_FFFF_FFFF_FFFF);
      chk("s2_flit1", got_q[1], 66'h0);
    end

    // 3: bad stop bit on the 4th byte discards the partial flit
    got_q.delete(); f0 = frame_cnt;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    rxd = 1'b1;
    repeat (20) step();
    send_flit(66'h1, 6'd0, 1'b0);
    drain();
    chk("s3_frame_err", W'(frame_cnt - f0), W'(1));
    chk("s3_count", W'(got_q.size()), W'(1));
    if (got_q.size() > 0) chk("s3_flit", got_q[0], 66'h1);

    // 4: idle timeout after 3 bytes
    got_q.delete(); t0 = to_cnt; to_n = -1;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'hBB, 1'b1, 1'b0);
    send_byte(8'hCC, 1'b1, 1'b0);
    for (int n = 1; n <= 250; n++) begin
      step();
      if (to_n < 0 && to_cnt != t0) to_n = n;
    end
    chk("s4_timeout_cycle", W'(to_n), W'(200));
    send_flit(66'h155, 6'd0, 1'b0);
    drain();
    chk("s4_timeout_cnt", W'(to_cnt - t0), W'(1));
    chk("s4_count", W'(got_q.size()), W'(1));
    if (got_q.size() > 0) chk("s4_flit", got_q[0], 66'h155);

    // 5: fill with ready low, 9th flit overflows
    got_q.delete(); o0 = ovf_cnt; exp_ovf = 0;
    fif.flit_ready = 1'b0;
    for (int v = 1; v <= 8; v++) send_flit(W'(v), 6'd0, 1'b0);
    step(); step();
    chk("s5_full", W'(fifo_full), W'(1));
    send_flit(W'(9), 6'd0, 1'b0);
    repeat (3) step();
    chk("s5_ovf_model", W'(ovf_cnt - o0), W'(exp_ovf));
    chk("s5_ovf", W'(ovf_cnt - o0), W'(1));
    drain();
    check_seq_inc("s5_flit", 8);

    // 6: pop on the exact push cycle while full
    got_q.delete(); o0 = ovf_cnt; exp_ovf = 0;
    fif.flit_ready = 1'b0;
    for (int v = 1; v <= 8; v++) send_flit(W'(v), 6'd0, 1'b0);
    send_flit(W'(9), 6'd0, 1'b1);
    drain();
    chk("s6_ovf", W'(ovf_cnt - o0), W'(0));
    check_seq_inc("s6_flit", 9);

    // 7: reset in the middle of byte 5
    got_q.delete();
    fif.flit_ready = 1'b0;
    send_flit(66'h77, 6'd0, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h04, 1'b1, 1'b0);
    send_bit(1'b0);
    rxd = 1'b1;
    repeat (3) step();
    chk_en = 1'b0;
    mq.delete();
    rst_n = 1'b0;
    #1;
    chk("s7_rst_valid", W'(fif.flit_valid), W'(0));
    chk("s7_rst_dout", fif.flit_dout, W'(0));
    chk("s7_rst_full", W'(fifo_full), W'(0));
    chk("s7_rst_errs", W'({frame_err, overflow_err, timeout_err}), W'(0));
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk_en = 1'b1;
    fif.flit_ready = 1'b1;
    send_flit(66'h3C, 6'd0, 1'b0);
    drain();
    chk("s7_count", W'(got_q.size()), W'(1));
    if (got_q.size() > 0) chk("s7_flit", got_q[0], 66'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
